// File: rtl/serial_subtractor.sv
// Bit-serial unsigned subtractor: computes a - b LSB first, one bit per clock,
// behind a start/busy/done handshake. Borrow-out is reported as emprunt.

module serial_subtractor_cell (
  input  logic x,
  input  logic y,
  input  logic bin,
  output logic d,
  output logic bout
);
  // Full-subtractor: mirror of the adder cell with borrow in place of carry.
  assign d    = x ^ y ^ bin;
  assign bout = (~x & y) | (~(x ^ y) & bin);
endmodule

module serial_subtractor #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             emprunt
);

  localparam int unsigned CW = $clog2(WIDTH);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

  logic [1:0]       state_q, state_d;
  logic [CW-1:0]    cnt_q,   cnt_d;
  logic [WIDTH-1:0] sa_q,    sa_d;
  logic [WIDTH-1:0] sb_q,    sb_d;
  logic [WIDTH-1:0] res_q,   res_d;
  logic             br_q,    br_d;
  logic [WIDTH-1:0] diff_q,  diff_d;
  logic             emp_q,   emp_d;

  logic             bit_d;
  logic             br_next;
  logic [WIDTH-1:0] res_shifted;

  serial_subtractor_cell u_cell (
    .x    (sa_q[0]),
    .y    (sb_q[0]),
    .bin  (br_q),
    .d    (bit_d),
    .bout (br_next)
  );

  assign res_shifted = {bit_d, res_q[WIDTH-1:1]};

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    sa_d    = sa_q;
    sb_d    = sb_q;
    res_d   = res_q;
    br_d    = br_q;
    diff_d  = diff_q;
    emp_d   = emp_q;

    case (state_q)
      S_IDLE, S_DONE: begin
        if (start) begin
          // diff/emprunt are left untouched so the previous result stays readable.
          state_d = S_RUN;
          sa_d    = a;
          sb_d    = b;
          br_d    = 1'b0;
          cnt_d   = '0;
        end else begin
          state_d = S_IDLE;
        end
      end

      S_RUN: begin
        sa_d  = {1'b0, sa_q[WIDTH-1:1]};
        sb_d  = {1'b0, sb_q[WIDTH-1:1]};
        res_d = res_shifted;
        br_d  = br_next;
        if (cnt_q == CNT_LAST) begin
          // Counter holds on the last bit so it never wraps inside an operation.
          diff_d  = res_shifted;
          emp_d   = br_next;
          state_d = S_DONE;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end

      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      sa_q    <= '0;
      sb_q    <= '0;
      res_q   <= '0;
      br_q    <= 1'b0;
      diff_q  <= '0;
      emp_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      sa_q    <= sa_d;
      sb_q    <= sb_d;
      res_q   <= res_d;
      br_q    <= br_d;
      diff_q  <= diff_d;
      emp_q   <= emp_d;
    end
  end

  assign busy    = (state_q == S_RUN);
  assign done    = (state_q == S_DONE);
  assign diff    = diff_q;
  assign emprunt = emp_q;

endmodule

// File: doc/serial_subtractor.md
# serial_subtractor

Bit-serial unsigned subtractor computing `a - b` one bit per clock, LSB first, with a full-subtractor (difference/borrow) cell and a registered borrow. It is the inverse of the team's 1-bit adder cell (`x`, `y` → `result`, `retenue`). It is wrapped in a start/busy/done handshake so that a controller can launch a subtraction and collect `diff` and `emprunt` (final borrow) when `done` pulses. It serves as the arithmetic back-end wherever the design needs subtraction without a full-width ripple chain.

## Interface
- `WIDTH`, default 8: operand and result width in bits, ≥ 2.

- `clk`  in  1  single system clock; all state updates on its rising edge.
- `reset`  in  1  asynchronous, active-high reset.
- `start`  in  1  launch request; sampled on rising edge of `clk` only when `busy` = 0.
- `a`  in  WIDTH  minuend, unsigned; captured on the accepting edge.
- `b`  in  WIDTH  subtrahend, unsigned; captured on the accepting edge.
- `busy`  out  1  high while bits are being processed.
- `done`  out  1  one-cycle pulse; `diff`/`emprunt` are valid from this cycle on.
- `diff`  out  WIDTH  `(a - b) mod 2^WIDTH`.
- `emprunt`  out  1  final borrow: 1 iff `a < b` (unsigned).

## Operation
- States:
  - IDLE: `busy`=0, `done`=0.
  - RUN: `busy`=1, `done`=0.
  - DONE: `busy`=0, `done`=1.
- State transitions:
  - IDLE & `start` → RUN.
  - RUN & bit counter = WIDTH-1 → DONE.
  - DONE & `start` → RUN.
  - DONE & !`start` → IDLE.
- Acceptance edge (IDLE/DONE with `start`=1):
  - Load shift regs `sa`←`a`, `sb`←`b`.
  - Clear the internal borrow register `br` and the bit counter.
  - `diff`/`emprunt` hold their previous values until the new result completes.
- Each RUN edge uses the bit cell `d = sa[0] ^ sb[0] ^ br` and `br_next = (~sa[0] & sb[0]) | (~(sa[0] ^ sb[0]) & br)`.
  - `sa`, `sb` shift right.
  - The result shift register shifts right with `d` entering at the MSB.
  - The counter increments.
- Last RUN edge (counter = WIDTH-1):
  - `diff` ← final shifted result.
  - `emprunt` ← `br_next`.
  - State → DONE.
- `start` while `busy`=1 is ignored; it is neither queued nor does it restart the operation.
- Changes on `a`/`b` after the acceptance edge have no effect on the running operation.
- Counter width is `$clog2(WIDTH)`. It never wraps inside an operation and is cleared on every acceptance.

## Timing
- Reset values: state IDLE, `busy`=0, `done`=0, `diff`=0, `emprunt`=0, `br`=0, counter=0, shift regs 0.
- Reset asserted mid-RUN aborts immediately (asynchronously): no `done` pulse is produced and outputs return to reset values.
- Start accepted at edge k:
  - `busy` is high for cycles k..k+WIDTH-1, i.e. exactly WIDTH cycles.
  - At edge k+WIDTH the state becomes DONE; `done` is high for one cycle and `diff`/`emprunt` update at that same edge.
  - Latency from accepting edge to `done` is WIDTH clocks.
- Back-to-back operation: `start` held high during the DONE cycle is accepted at edge k+WIDTH+1, giving a throughput of one result per WIDTH+1 cycles. `done` drops at that edge and `busy` rises.
- `diff`/`emprunt` remain stable from `done` until the next completion or reset.
- `start` sampled at the same edge that reset deasserts is accepted normally.

## Test plan
- WIDTH=8: `a`=5, `b`=3, pulse `start` → `busy` high for 8 cycles, then `done` pulse with `diff`=2, `emprunt`=0.
- WIDTH=8: `a`=3, `b`=5 → `diff`=0xFE, `emprunt`=1. Also `a`=0x00, `b`=0x01 → `diff`=0xFF, `emprunt`=1. Also `a`=`b`=0xA5 → `diff`=0, `emprunt`=0.
- Edge operands: `a`=0xFF, `b`=0x00 → 0xFF/0; `a`=0x80, `b`=0x7F → 0x01/0; `a`=0x7F, `b`=0x80 → 0xFF/1.
- Handshake:
  - Pulse `start` with 10−4, then pulse `start` again at cycle 3 of RUN with 1−2 → ignored; single `done` with `diff`=6.
  - Changing `a`/`b` mid-RUN does not alter the result.
- Back-to-back: `start` held high continuously with operands 9−1 then 1−9 → `done` pulses spaced exactly 9 cycles apart, giving 0x08/0 then 0xF8/1.
- Assert `reset` at cycle 4 of RUN → `busy`, `done`, `diff`, `emprunt` read 0 immediately and no `done` pulse follows. A subsequent 7−7 after reset release → 0/0.
